// File: rtl/hop_chain_checker.sv
// hop_chain_checker: drives LFSR patterns into LANES hop chains and counts per-lane mismatches on the returned bits.
module hop_chain_checker #(
    parameter int          LANES   = 4,
    parameter int          LATENCY = 4,
    parameter int          RUN_LEN = 256,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          ERR_W   = 16
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             go,
    output logic [LANES-1:0] start,
    input  logic [LANES-1:0] ret,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [LANES-1:0] err_mask
);
    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;
    localparam int CNT_MAX = (RUN_LEN > LATENCY) ? RUN_LEN : LATENCY;
    localparam int CW = $clog2(CNT_MAX + 1);
    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [15:0]      r_lfsr, w_lfsr_step;
    logic [LANES-1:0] r_start, r_mask, w_mism;
    logic [LANES:0]   r_dl [LATENCY];
    logic [ERR_W-1:0] r_err, w_err_next;
    logic [ERR_W+5:0] w_sum;
    logic             r_pass, w_launch, w_cmp;
    assign w_launch    = go && (r_state == S_IDLE || r_state == S_DONE);
    assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_cmp       = r_dl[LATENCY-1][LANES];
    assign w_mism      = w_cmp ? (ret ^ r_dl[LATENCY-1][LANES-1:0]) : '0;
    always_ff @(posedge clock0) begin
        if (rst1) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
        unique case (r_state)
            S_IDLE, S_DONE: if (go) begin
                w_state_next = S_FLUSH;
                w_cnt_next   = CW'(LATENCY - 1);
            end
            S_FLUSH: if (r_cnt == '0) begin
                w_state_next = S_RUN;
                w_cnt_next   = CW'(RUN_LEN - 1);
            end
            S_RUN: if (r_cnt == '0) begin
                w_state_next = S_DRAIN;
                w_cnt_next   = CW'(LATENCY - 1);
            end
            S_DRAIN: if (r_cnt == '0) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end
    // start is registered from the LFSR value held on entry to each RUN cycle
    always_ff @(posedge clock0) begin
        if (rst1) begin
            r_lfsr  <= SEED_EFF;
            r_start <= '0;
        end else begin
            r_lfsr  <= w_launch ? SEED_EFF : (w_state_next == S_RUN) ? w_lfsr_step : r_lfsr;
            r_start <= (w_state_next == S_RUN) ? r_lfsr[LANES-1:0] : '0;
        end
    end
    always_ff @(posedge clock0) begin
        if (rst1) begin
            for (int i = 0; i < LATENCY; i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= {r_state == S_RUN, r_start};
            for (int i = 1; i < LATENCY; i++) r_dl[i] <= r_dl[i-1];
        end
    end
    always_comb begin
        w_sum = {6'd0, r_err};
        for (int i = 0; i < LANES; i++) w_sum = w_sum + {{(ERR_W+5){1'b0}}, w_mism[i]};
        w_err_next = (w_sum > {6'd0, {ERR_W{1'b1}}}) ? '1 : w_sum[ERR_W-1:0];
    end
    always_ff @(posedge clock0) begin
        if (rst1) begin
            r_err  <= '0;
            r_mask <= '0;
            r_pass <= 1'b0;
        end else begin
            r_err  <= w_launch ? '0 : w_err_next;
            r_mask <= w_launch ? '0 : (r_mask | w_mism);
            r_pass <= (w_state_next == S_DONE) && (w_err_next == '0);
        end
    end
    assign start     = r_start;
    assign busy      = (r_state == S_FLUSH) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign err_mask  = r_mask;
endmodule

// File: tb/tb_hop_chain_checker.sv
// tb_hop_chain_checker: randomized closed-loop bench with a modelled hop DUT and an LFSR sequence reference.
module tb_hop_chain_checker;
    localparam int L = 4;
    localparam int R = 256;
    localparam int SL = 2;
    localparam int SR = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 1'b0;
    logic go_s = 1'b0;
    logic [3:0] start, ret, start_s, ret_s, err_mask, err_mask_s;
    logic [3:0] stuck = 4'h0;
    logic [3:0] noise = 4'h0;
    logic busy, done, pass, busy_s, done_s, pass_s;
    logic [15:0] err_count;
    logic [3:0] err_count_s;
    logic [3:0] ch [4];
    logic [15:0] seq [R+1];
    int dsel = 4;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        ch[0] <= start;
        ch[1] <= ch[0];
        ch[2] <= ch[1];
        ch[3] <= ch[2];
    end
    assign ret   = (((dsel == 3) ? ch[2] : ch[3]) & ~stuck) ^ noise;
    assign ret_s = 4'hF;
    hop_chain_checker dut (
        .clock0(clk), .rst1(rst), .go(go), .start(start), .ret(ret), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .err_mask(err_mask)
    );
    hop_chain_checker #(.LATENCY(SL), .RUN_LEN(SR), .ERR_W(4)) dut_sat (
        .clock0(clk), .rst1(rst), .go(go_s), .start(start_s), .ret(ret_s), .busy(busy_s),
        .done(done_s), .pass(pass_s), .err_count(err_count_s), .err_mask(err_mask_s)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [3:0] st_run(input int j);
        return (j >= 0 && j < R) ? seq[j][3:0] : 4'h0;
    endfunction
    task automatic run_test(input int d, input logic [3:0] m);
        int e = 0;
        logic [3:0] em = 4'h0;
        logic [3:0] mism;
        for (int k = 0; k < R; k++) begin
            mism = (st_run(k + L - d) & ~m) ^ seq[k][3:0];
            em |= mism;
            e += $countones(mism);
        end
        if (e > 65535) e = 65535;
        dsel = d;
        stuck = m;
        @(negedge clk);
        go = 1'b1;
        for (int n = 1; n <= 2*L + R + 1; n++) begin
            @(negedge clk);
            chk("busy", busy, n <= 2*L + R);
            chk("done", done, n == 2*L + R + 1);
            chk("start", start, (n >= L + 1 && n <= L + R) ? seq[n-L-1][3:0] : 4'h0);
            if (n == 1) begin
                chk("err_clr", err_count, 0);
                chk("mask_clr", err_mask, 0);
            end
            go = (n <= 2*L + R) ? 1'($urandom_range(0, 1)) : 1'b0;
            noise = (n <= 2*L || n == 2*L + R + 1) ? 4'($urandom) : 4'h0;
        end
        chk("err_count", err_count, e);
        chk("err_mask", err_mask, em);
        chk("pass", pass, e == 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end
    initial begin
        int e;
        logic [3:0] em;
        seq[0] = 16'hACE1;
        for (int k = 1; k <= R; k++)
            seq[k] = {seq[k-1][14:0], seq[k-1][15] ^ seq[k-1][13] ^ seq[k-1][12] ^ seq[k-1][10]};
        repeat (6) begin
            @(negedge clk);
            noise = 4'($urandom);
        end
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_mask", err_mask, 0);
        rst = 1'b0;
        noise = 4'h0;
        @(negedge clk);
        chk("idle_start", start, 0);
        chk("idle_busy", busy, 0);
        run_test(4, 4'h0);
        run_test(4, 4'b0100);
        run_test(3, 4'h0);
        run_test(4, 4'($urandom));
        run_test(4, 4'h0);
        stuck = 4'b0100;
        dsel = 4;
        @(negedge clk);
        go = 1'b1;
        for (int n = 1; n <= L + 1 + 100; n++) begin
            @(negedge clk);
            go = 1'($urandom_range(0, 1));
            chk("ab_busy", busy, 1);
        end
        rst = 1'b1;
        go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("ab_start", start, 0);
        chk("ab_busy0", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_pass", pass, 0);
        chk("ab_err", err_count, 0);
        chk("ab_mask", err_mask, 0);
        @(negedge clk);
        chk("ab_idle", busy, 0);
        run_test(4, 4'h0);
        e = 0;
        em = 4'h0;
        for (int k = 0; k < SR; k++) begin
            em |= ~seq[k][3:0];
            e += $countones(~seq[k][3:0]);
        end
        if (e > 15) e = 15;
        go_s = 1'b1;
        @(negedge clk);
        go_s = 1'b0;
        for (int n = 1; n <= 2*SL + SR + 1; n++) begin
            chk("sat_done", done_s, n == 2*SL + SR + 1);
            if (n <= 2*SL + SR) @(negedge clk);
        end
        chk("sat_err", err_count_s, e);
        chk("sat_mask", err_mask_s, em);
        chk("sat_pass", pass_s, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
